clock_set_ctrl: RTL

- Consumes the three debounced single-cycle key pulses (mode, turn, change) from the key debounce stage.
- Runs the multi-function clock's control FSM and timekeeping: hh:mm:ss counter, time set, alarm set, alarm enable and alarm ring.
- Outputs feed the display/blink driver and the buzzer driver downstream.

---
 rtl/clock_set_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: control FSM and timekeeping for a multi-function clock.
// Runs an hh:mm:ss counter from a 1 s prescaler, handles time set, alarm set,
// alarm enable and the alarm ring from three debounced key pulses.
//
// Ports:
//   clk        - main clock
//   rst_n      - asynchronous reset, active low
//   key_pulse  - 1-cycle key presses: [0] mode, [1] turn, [2] change
//   state      - 0 RUN, 1 SET_TIME, 2 SET_ALARM
//   field      - edited field: 0 HOUR, 1 MIN, 2 SEC
//   hour/minute/second - current time
//   alm_hour/alm_min   - alarm time
//   alarm_en   - alarm armed
//   alarm_ring - buzzer request
//   sec_tick   - 1-cycle pulse at each second rollover
//   blink      - blink phase for the edited field (high in first half-second)
module clock_set_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_pulse,
    output logic [1:0] state,
    output logic [1:0] field,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic       alarm_en,
    output logic       alarm_ring,
    output logic       sec_tick,
    output logic       blink
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECS - 1);
    localparam logic [RW-1:0] RING_ONE   = RW'(1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    localparam logic [1:0] HOUR = 2'd0;
    localparam logic [1:0] MIN  = 2'd1;
    localparam logic [1:0] SEC  = 2'd2;

    state_t          cur, nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [RW-1:0]   ring_cnt, rcnt_nxt;
    logic [1:0]      field_nxt;
    logic [4:0]      hour_nxt, alm_hour_nxt;
    logic [5:0]      minute_nxt, second_nxt, alm_min_nxt;
    logic            en_nxt, ring_nxt, blink_nxt;
    logic            wrap;
    logic            mode_key, turn_key, change_key;

    // Priority mode > turn > change; lower-priority bits are dropped.
    assign mode_key   = key_pulse[0];
    assign turn_key   = key_pulse[1] & ~key_pulse[0];
    assign change_key = key_pulse[2] & ~key_pulse[1] & ~key_pulse[0];

    // Time is frozen in SET_TIME: the prescaler never reaches its terminal count.
    assign wrap  = (cur != SET_TIME) && (presc == PRESC_MAX);
    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= RUN;
        else        cur <= nxt;
    end

    always_comb begin
        nxt          = cur;
        field_nxt    = field;
        hour_nxt     = hour;
        minute_nxt   = minute;
        second_nxt   = second;
        alm_hour_nxt = alm_hour;
        alm_min_nxt  = alm_min;
        en_nxt       = alarm_en;
        ring_nxt     = alarm_ring;
        rcnt_nxt     = ring_cnt;
        presc_nxt    = (cur == SET_TIME || wrap) ? '0 : presc + PRESC_ONE;

        if (wrap) begin
            if (second == 6'd59) begin
                second_nxt = 6'd0;
                if (minute == 6'd59) begin
                    minute_nxt = 6'd0;
                    hour_nxt   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    minute_nxt = minute + 6'd1;
                end
            end else begin
                second_nxt = second + 6'd1;
            end
            if (alarm_ring) begin
                if (ring_cnt == RING_LAST) ring_nxt = 1'b0;
                else                       rcnt_nxt = ring_cnt + RING_ONE;
            end
            // Match is against the time being written on this edge.
            if (alarm_en && hour_nxt == alm_hour && minute_nxt == alm_min &&
                second_nxt == 6'd0) begin
                ring_nxt = 1'b1;
                rcnt_nxt = '0;
            end
        end

        if (alarm_ring && key_pulse != 3'b000) begin
            // Any press silences the buzzer and is otherwise swallowed.
            ring_nxt = 1'b0;
        end else if (mode_key) begin
            field_nxt = HOUR;
            case (cur)
                RUN: begin
                    nxt       = SET_TIME;
                    presc_nxt = '0;
                end
                SET_TIME: nxt = SET_ALARM;
                default:  nxt = RUN;
            endcase
        end else if (turn_key) begin
            case (cur)
                SET_TIME:  field_nxt = (field == SEC) ? HOUR : field + 2'd1;
                SET_ALARM: field_nxt = (field == HOUR) ? MIN : HOUR;
                default:   field_nxt = field;
            endcase
        end else if (change_key) begin
            case (cur)
                SET_TIME: begin
                    case (field)
                        HOUR:    hour_nxt   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                        MIN:     minute_nxt = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                        default: second_nxt = 6'd0;
                    endcase
                end
                SET_ALARM: begin
                    if (field == HOUR)
                        alm_hour_nxt = (alm_hour == 5'd23) ? 5'd0 : alm_hour + 5'd1;
                    else
                        alm_min_nxt = (alm_min == 6'd59) ? 6'd0 : alm_min + 6'd1;
                end
                default: en_nxt = ~alarm_en;
            endcase
        end

        // Disarming always silences the buzzer.
        if (!en_nxt) ring_nxt = 1'b0;

        blink_nxt = (presc_nxt < PRESC_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            ring_cnt   <= '0;
            field      <= HOUR;
            hour       <= 5'd0;
            minute     <= 6'd0;
            second     <= 6'd0;
            alm_hour   <= 5'd0;
            alm_min    <= 6'd0;
            alarm_en   <= 1'b0;
            alarm_ring <= 1'b0;
            sec_tick   <= 1'b0;
            blink      <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            ring_cnt   <= rcnt_nxt;
            field      <= field_nxt;
            hour       <= hour_nxt;
            minute     <= minute_nxt;
            second     <= second_nxt;
            alm_hour   <= alm_hour_nxt;
            alm_min    <= alm_min_nxt;
            alarm_en   <= en_nxt;
            alarm_ring <= ring_nxt;
            sec_tick   <= wrap;
            blink      <= blink_nxt;
        end
    end
endmodule
